signed_seq_divider: RTL and testbench

Multi-cycle signed integer divider for the matrix datapath. It is the inverse operation of the multiply/accumulate path and handles normalisation and scaling of matrix results. It uses a start/done handshake and a restoring radix-2 algorithm on operand magnitudes, one quotient bit per cycle, with sign correction at the end. Rounding truncates toward zero: the remainder takes the sign of the dividend.

---
 rtl/signed_seq_divider_pkg.sv | 14 +
 rtl/signed_seq_divider_div_restore_step.sv | 24 ++
 rtl/signed_seq_divider.sv | 119 +++++++++++
 tb/tb_signed_seq_divider.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/signed_seq_divider_pkg.sv
// Shared definitions for the sequential signed divider.
package signed_seq_divider_pkg;

  localparam int unsigned BIT_WIDTH = 16;
  localparam int unsigned CNT_W     = $clog2(BIT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/signed_seq_divider_div_restore_step.sv
// One restoring-division step.
// The partial remainder is shifted left, and the next dividend bit is appended.
// The shifted value is then trial-subtracted against the divisor magnitude.
// The top bit of rem_in is always zero because R < |divisor| <= 2^(W-1).
module div_restore_step #(
  parameter int unsigned W = 16
) (
  input  logic [W:0]   rem_in,
  input  logic         next_bit,
  input  logic [W-1:0] dvsr_mag,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W+1:0] shifted;

  // Keep the trial difference when it is non-negative, otherwise restore.
  always_comb begin
    shifted = {rem_in, next_bit};
    q_bit   = (shifted >= {2'b00, dvsr_mag});
    rem_out = q_bit ? (W+1)'(shifted - {2'b00, dvsr_mag}) : (W+1)'(shifted);
  end

endmodule

// File: rtl/signed_seq_divider.sv
// Multi-cycle signed integer divider with a start/done handshake.
// It runs a restoring radix-2 division on the operand magnitudes.
// Signs are corrected at the end, so the quotient truncates toward zero.
module signed_seq_divider #(
  parameter int unsigned BIT_WIDTH = signed_seq_divider_pkg::BIT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] dividend,
  input  logic [BIT_WIDTH-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] quotient,
  output logic [BIT_WIDTH-1:0] remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  import signed_seq_divider_pkg::*;

  localparam int unsigned CW = $clog2(BIT_WIDTH + 1);
  localparam logic [BIT_WIDTH-1:0] MIN_VAL = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BIT_WIDTH-1:0] shq;       // dividend bits shift out, quotient bits shift in
  logic [BIT_WIDTH-1:0] dvsr_mag;
  logic [BIT_WIDTH:0]   rem;
  logic [BIT_WIDTH:0]   rem_next;
  logic                 q_bit;
  logic                 sign_q;
  logic                 sign_r;

  function automatic logic [BIT_WIDTH-1:0] magnitude(input logic [BIT_WIDTH-1:0] v);
    return v[BIT_WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  div_restore_step #(.W(BIT_WIDTH)) u_step (
    .rem_in   (rem),
    .next_bit (shq[BIT_WIDTH-1]),
    .dvsr_mag (dvsr_mag),
    .rem_out  (rem_next),
    .q_bit    (q_bit)
  );

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shq         <= '0;
      dvsr_mag    <= '0;
      rem         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sign_q <= dividend[BIT_WIDTH-1] ^ divisor[BIT_WIDTH-1];
            sign_r <= dividend[BIT_WIDTH-1];
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              done        <= 1'b1;
              state       <= DONE;
            end else if (dividend == MIN_VAL && divisor == '1) begin
              quotient    <= MIN_VAL;
              remainder   <= '0;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              shq      <= magnitude(dividend);
              dvsr_mag <= magnitude(divisor);
              rem      <= '0;
              cnt      <= CW'(BIT_WIDTH);
              busy     <= 1'b1;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          shq <= {shq[BIT_WIDTH-2:0], q_bit};
          rem <= rem_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          quotient    <= sign_q ? (~shq + 1'b1) : shq;
          remainder   <= sign_r ? (~rem[BIT_WIDTH-1:0] + 1'b1) : rem[BIT_WIDTH-1:0];
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_seq_divider.sv
// Self-checking bench for signed_seq_divider (BIT_WIDTH = 16).
module tb_signed_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  signed_seq_divider #(.BIT_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected state for the current operation, plus the results that must be held.
  bit          act = 1'b0;
  bit          fast;
  int          e0;
  int          dcyc;
  logic [15:0] cur_q, cur_r;
  logic        cur_dz, cur_ov;
  logic [15:0] held_q = '0, held_r = '0;
  logic        held_dz = 1'b0, held_ov = 1'b0;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endfunction

  // Model for truncating signed division, including both special cases.
  function automatic void model(input int a, input int b, output logic [15:0] q,
                                output logic [15:0] r, output logic dz, output logic ov);
    if (b == 0) begin
      q = 16'hFFFF; r = 16'(a); dz = 1'b1; ov = 1'b0;
    end else if (a == -32768 && b == -1) begin
      q = 16'h8000; r = 16'h0000; dz = 1'b0; ov = 1'b1;
    end else begin
      q = 16'(a / b); r = 16'(a % b); dz = 1'b0; ov = 1'b0;
    end
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic        eb, ed, edz, eov;
    logic [15:0] eq, er;
    if (rst_n) begin
      eb = act && !fast && (cyc >= e0) && (cyc < e0 + dcyc);
      ed = act && (cyc == e0 + dcyc);
      if (act && cyc >= e0 + dcyc) begin
        eq = cur_q; er = cur_r; edz = cur_dz; eov = cur_ov;
      end else begin
        eq = held_q; er = held_r; edz = held_dz; eov = held_ov;
      end
      chk("busy", 32'(busy), 32'(eb));
      chk("done", 32'(done), 32'(ed));
      chk("quotient", 32'(quotient), 32'(eq));
      chk("remainder", 32'(remainder), 32'(er));
      chk("div_by_zero", 32'(div_by_zero), 32'(edz));
      chk("overflow", 32'(overflow), 32'(eov));
    end
  end

  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    int ai, bi;
    ai = $signed(a);
    bi = $signed(b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (act) begin
      held_q = cur_q; held_r = cur_r; held_dz = cur_dz; held_ov = cur_ov;
    end
    model(ai, bi, cur_q, cur_r, cur_dz, cur_ov);
    fast = (b == 16'h0000) || (a == 16'h8000 && b == 16'hFFFF);
    dcyc = fast ? 0 : 17;
    e0   = cyc + 1;
    act  = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit noisy,
                       input bit done_poke);
    launch(a, b);
    for (int i = 0; i < dcyc; i++) begin
      if (noisy) begin
        start    = 1'($urandom);
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (done_poke) begin
      start    = 1'b1;
      dividend = 16'($urandom);
      divisor  = 16'($urandom);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    act   = 1'b0;
    held_q = '0; held_r = '0; held_dz = 1'b0; held_ov = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_div_by_zero", 32'(div_by_zero), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pq, pr, ra, rb;
    logic        pdz, pov;
    logic [15:0] specials [6];
    specials[0] = 16'h8000; specials[1] = 16'hFFFF; specials[2] = 16'h0000;
    specials[3] = 16'h7FFF; specials[4] = 16'h0001; specials[5] = 16'h8001;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;

    // Hand-computed values that pin the model itself.
    model(100, 7, pq, pr, pdz, pov);
    chk("pin_100_7_q", 32'(pq), 32'd14);
    chk("pin_100_7_r", 32'(pr), 32'd2);
    model(-100, 7, pq, pr, pdz, pov);
    chk("pin_m100_7_q", 32'(pq), 32'h0000_FFF2);
    chk("pin_m100_7_r", 32'(pr), 32'h0000_FFFE);
    model(-32768, 3, pq, pr, pdz, pov);
    chk("pin_min_3_q", 32'(pq), 32'h0000_D556);
    chk("pin_min_3_r", 32'(pr), 32'h0000_FFFE);
    model(32767, -32768, pq, pr, pdz, pov);
    chk("pin_max_min_q", 32'(pq), 32'd0);
    chk("pin_max_min_r", 32'(pr), 32'd32767);
    model(5, 0, pq, pr, pdz, pov);
    chk("pin_div0_q", 32'(pq), 32'h0000_FFFF);
    chk("pin_div0_dz", 32'(pdz), 32'd1);

    do_reset();

    issue(16'd100, 16'd7, 1'b0, 1'b0);
    issue(-16'sd100, 16'd7, 1'b0, 1'b0);
    issue(16'd100, -16'sd7, 1'b0, 1'b0);
    issue(-16'sd100, -16'sd7, 1'b0, 1'b0);
    issue(16'h8000, 16'hFFFF, 1'b0, 1'b0);
    issue(16'd5, 16'd0, 1'b0, 1'b0);
    issue(16'h8000, 16'd1, 1'b0, 1'b0);
    issue(16'd32767, 16'h8000, 1'b0, 1'b0);
    issue(16'h8000, 16'd3, 1'b0, 1'b0);
    // Start pulses mid-CALC are ignored, as is a start during DONE.
    issue(16'd1234, -16'sd56, 1'b1, 1'b1);
    issue(-16'sd77, 16'd5, 1'b0, 1'b0);

    // Reset in the middle of a calculation.
    launch(16'd1000, 16'd3);
    repeat (5) @(negedge clk);
    do_reset();
    repeat (20) @(negedge clk);
    issue(16'd9, 16'd3, 1'b0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 5) == 0) ra = specials[$urandom_range(0, 5)];
      if ($urandom_range(0, 5) == 0) rb = specials[$urandom_range(0, 5)];
      issue(ra, rb, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
